// File: rtl/ps2_key_encoder.sv
// PS/2 set-2 receiver and game-key encoder: emits one 5-bit command code per make event.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity rejection of received bytes.
module ps2_key_encoder #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       PS2_CLK,
  input  logic       PS2_DAT,
  output logic [4:0] KEY_PRESSED,
  output logic       key_valid,
  output logic       frame_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  localparam logic [15:0] TMO       = 16'(TIMEOUT_CYCLES);
  localparam logic [4:0]  IDLE_CODE = 5'd31;

  logic       clk_s1_q, clk_s2_q, clk_s3_q;
  logic       dat_s1_q, dat_s2_q;
  logic       fall;
  logic       dat;

  state_t     state_q, state_d;
  logic [2:0] bitcnt_q, bitcnt_d;
  logic [7:0] byte_q, byte_d;
  logic       ext_q, ext_d;
  logic       brk_q, brk_d;
  logic [15:0] tmo_q, tmo_d;
  logic [4:0] code_q, code_d;
  logic       valid_q, valid_d;
  logic       err_q, err_d;
  logic       par_bad;
  logic       map_hit;
  logic [4:0] map_code;
`ifdef PS2_PARITY_CHECK_EN
  logic       parity_q, parity_d;
`endif

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      clk_s1_q <= 1'b1;
      clk_s2_q <= 1'b1;
      clk_s3_q <= 1'b1;
      dat_s1_q <= 1'b1;
      dat_s2_q <= 1'b1;
    end else begin
      clk_s1_q <= PS2_CLK;
      clk_s2_q <= clk_s1_q;
      clk_s3_q <= clk_s2_q;
      dat_s1_q <= PS2_DAT;
      dat_s2_q <= dat_s1_q;
    end
  end

  assign fall = clk_s3_q & ~clk_s2_q;
  assign dat  = dat_s2_q;

  // Game key map, indexed by {extended-prefix seen, scan code}.
  always_comb begin
    map_hit  = 1'b1;
    map_code = IDLE_CODE;
    case ({ext_q, byte_q})
      9'h01D: map_code = 5'd0;
      9'h01B: map_code = 5'd1;
      9'h01C: map_code = 5'd2;
      9'h023: map_code = 5'd3;
      9'h175: map_code = 5'd4;
      9'h172: map_code = 5'd5;
      9'h16B: map_code = 5'd6;
      9'h174: map_code = 5'd7;
      9'h043: map_code = 5'd8;
      9'h042: map_code = 5'd9;
      9'h03B: map_code = 5'd10;
      9'h04B: map_code = 5'd11;
      9'h075: map_code = 5'd12;
      9'h073: map_code = 5'd13;
      9'h06B: map_code = 5'd14;
      9'h074: map_code = 5'd15;
      9'h029: map_code = 5'd16;
      default: map_hit = 1'b0;
    endcase
  end

  always_comb begin
`ifdef PS2_PARITY_CHECK_EN
    par_bad = ~(^{byte_q, parity_q});
`else
    par_bad = 1'b0;
`endif
  end

  always_comb begin
    state_d  = state_q;
    bitcnt_d = bitcnt_q;
    byte_d   = byte_q;
    ext_d    = ext_q;
    brk_d    = brk_q;
    tmo_d    = tmo_q;
    code_d   = IDLE_CODE;
    valid_d  = 1'b0;
    err_d    = 1'b0;
`ifdef PS2_PARITY_CHECK_EN
    parity_d = parity_q;
`endif

    if (state_q == S_IDLE || fall) begin
      tmo_d = '0;
    end else if (tmo_q != '1) begin
      tmo_d = tmo_q + 16'd1;
    end

    // A stalled frame is abandoned before any edge in the same cycle is looked at.
    if (state_q != S_IDLE && tmo_q == TMO) begin
      state_d = S_IDLE;
      err_d   = 1'b1;
      ext_d   = 1'b0;
      brk_d   = 1'b0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat) begin
            state_d  = S_DATA;
            bitcnt_d = '0;
          end
        end
        S_DATA: begin
          byte_d[bitcnt_q] = dat;
          if (bitcnt_q == 3'd7) state_d = S_PARITY;
          else                  bitcnt_d = bitcnt_q + 3'd1;
        end
        S_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
          parity_d = dat;
`endif
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (par_bad) begin
            err_d = 1'b1;
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else if (!dat) begin
            err_d = 1'b1;
          end else if (byte_q == 8'hE0) begin
            ext_d = 1'b1;
          end else if (byte_q == 8'hF0) begin
            brk_d = 1'b1;
          end else if (brk_q) begin
            ext_d = 1'b0;
            brk_d = 1'b0;
          end else begin
            ext_d = 1'b0;
            if (map_hit) begin
              code_d  = map_code;
              valid_d = 1'b1;
            end
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state_q  <= S_IDLE;
      bitcnt_q <= '0;
      byte_q   <= '0;
      ext_q    <= 1'b0;
      brk_q    <= 1'b0;
      tmo_q    <= '0;
      code_q   <= IDLE_CODE;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      bitcnt_q <= bitcnt_d;
      byte_q   <= byte_d;
      ext_q    <= ext_d;
      brk_q    <= brk_d;
      tmo_q    <= tmo_d;
      code_q   <= code_d;
      valid_q  <= valid_d;
      err_q    <= err_d;
`ifdef PS2_PARITY_CHECK_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign KEY_PRESSED = code_q;
  assign key_valid   = valid_q;
  assign frame_err   = err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// Randomized and directed PS/2 frame stimulus checked every cycle against a
// frame-level model of the key encoder (scan-code map, prefix flags, error timing).
module tb_ps2_key_encoder;

  localparam int unsigned TMO = 200;
  localparam int unsigned H   = 6;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2c = 1'b1;
  logic       ps2d = 1'b1;
  logic [4:0] key;
  logic       kv;
  logic       ferr;

  ps2_key_encoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50   (clk),
    .reset      (rst),
    .PS2_CLK    (ps2c),
    .PS2_DAT    (ps2d),
    .KEY_PRESSED(key),
    .key_valid  (kv),
    .frame_err  (ferr)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int unsigned at;
    bit          err;
    logic [4:0]  code;
  } ev_t;

  ev_t q[$];
  int  vectors = 0;
  int  miscompares = 0;
  bit  chk_en = 1'b0;
  bit  m_ext = 1'b0;
  bit  m_brk = 1'b0;

  logic [4:0] e_code;
  bit         e_valid, e_err;

  function automatic int map_code(input bit e, input logic [7:0] b);
    logic [7:0] keys[17];
    bit         exts[17];
    keys = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B, 8'h74, 8'h43,
             8'h42, 8'h3B, 8'h4B, 8'h75, 8'h73, 8'h6B, 8'h74, 8'h29};
    exts = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    for (int i = 0; i < 17; i++)
      if (keys[i] == b && exts[i] == e) return i;
    return -1;
  endfunction

  // Returns -2 for a frame error, -1 for no output, else the command code.
  function automatic int model_byte(input logic [7:0] b, input bit par_bad, input bit stop_bad);
    int r;
    if (PCHK && par_bad) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      return -2;
    end
    if (stop_bad) return -2;
    if (b == 8'hE0) begin m_ext = 1'b1; return -1; end
    if (b == 8'hF0) begin m_brk = 1'b1; return -1; end
    if (m_brk) begin
      m_ext = 1'b0;
      m_brk = 1'b0;
      return -1;
    end
    r = map_code(m_ext, b);
    m_ext = 1'b0;
    return r;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      e_code  = 5'd31;
      e_valid = 1'b0;
      e_err   = 1'b0;
      while (q.size() > 0 && q[0].at < cyc) begin
        vectors++;
        miscompares++;
        $display("FAIL missed_event: at cycle %0d expected event (err=%b code=%0d) never seen", q[0].at, q[0].err, q[0].code);
        void'(q.pop_front());
      end
      if (q.size() > 0 && q[0].at == cyc) begin
        if (q[0].err) e_err = 1'b1;
        else begin
          e_valid = 1'b1;
          e_code  = q[0].code;
        end
        void'(q.pop_front());
      end
      vectors++;
      if (key !== e_code || kv !== e_valid || ferr !== e_err) begin
        miscompares++;
        $display("FAIL outputs cycle %0d: got code=%0d valid=%b err=%b, want code=%0d valid=%b err=%b",
                 cyc, key, kv, ferr, e_code, e_valid, e_err);
      end
    end
  end

  task automatic push_pred(input int pred, input int unsigned at);
    ev_t e;
    if (pred == -1) return;
    e.at   = at;
    e.err  = (pred == -2);
    e.code = (pred >= 0) ? 5'(pred) : 5'd31;
    q.push_back(e);
  endtask

  task automatic ps2_bit(input logic b, output int unsigned n);
    @(posedge clk); #1 ps2d = b;
    repeat (H) @(posedge clk);
    #1 ps2c = 1'b0;
    n = cyc;
    repeat (H) @(posedge clk);
    #1 ps2c = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] b, input bit flip, input bit stop, output int pred);
    int unsigned n;
    ps2_bit(1'b0, n);
    for (int i = 0; i < 8; i++) ps2_bit(b[i], n);
    ps2_bit((~^b) ^ flip, n);
    @(posedge clk); #1 ps2d = stop;
    repeat (H) @(posedge clk);
    #1 ps2c = 1'b0;
    n = cyc;
    pred = model_byte(b, flip, !stop);
    push_pred(pred, n + 3);
    repeat (H) @(posedge clk);
    #1 ps2c = 1'b1;
  endtask

  task automatic frame_expect(input logic [7:0] b, input bit flip, input bit stop, input int want);
    int pred;
    send_frame(b, flip, stop, pred);
    vectors++;
    if (pred != want) begin
      miscompares++;
      $display("FAIL model_pin byte %h: model gives %0d, hand value %0d", b, pred, want);
    end
  endtask

  task automatic partial_frame(input int unsigned nbits, output int unsigned n);
    ps2_bit(1'b0, n);
    for (int unsigned i = 0; i < nbits; i++) ps2_bit(1'($urandom_range(0, 1)), n);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned n;
    int          pred;
    logic [7:0]  pool[17];
    logic [7:0]  b;
    pool = '{8'hE0, 8'hF0, 8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h75, 8'h72, 8'h6B,
             8'h74, 8'h43, 8'h42, 8'h3B, 8'h4B, 8'h73, 8'h29, 8'h00};

    @(posedge clk); #1 chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);

    frame_expect(8'h1D, 0, 1, 0);
    frame_expect(8'hE0, 0, 1, -1);
    frame_expect(8'h75, 0, 1, 4);
    frame_expect(8'h75, 0, 1, 12);
    frame_expect(8'hE0, 0, 1, -1);
    frame_expect(8'hF0, 0, 1, -1);
    frame_expect(8'h75, 0, 1, -1);
    frame_expect(8'hF0, 0, 1, -1);
    frame_expect(8'h1D, 0, 1, -1);
    frame_expect(8'h29, 0, 1, 16);
    frame_expect(8'h23, 1, 1, PCHK ? -2 : 3);

    partial_frame(4, n);
    push_pred(-2, n + 4 + TMO);
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (TMO + 20) @(posedge clk);
    frame_expect(8'h42, 0, 1, 9);

    frame_expect(8'h43, 0, 0, -2);

    partial_frame(3, n);
    @(posedge clk); #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_ext = 1'b0;
    m_brk = 1'b0;
    repeat (3) @(posedge clk);
    frame_expect(8'h4B, 0, 1, 11);

    // Typematic repeat: same make twice back to back.
    frame_expect(8'h1B, 0, 1, 1);
    frame_expect(8'h1B, 0, 1, 1);

    for (int i = 0; i < 120; i++) begin
      b = pool[$urandom_range(0, 16)];
      if (b == 8'h00) b = 8'($urandom);
      send_frame(b, $urandom_range(0, 9) == 0, $urandom_range(0, 11) != 0, pred);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 30)) @(posedge clk);
    end

    repeat (20) @(posedge clk);
    if (q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL pending_events: got %0d unconsumed expected events, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
